// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit floating-point adder slice:
// field layout, NaN/Inf classification and the sequencer state encoding.
package fp8_pkg;

   localparam int unsigned FP8_SIGN_BIT = 7;
   localparam int unsigned FP8_EXP_MSB  = 6;
   localparam int unsigned FP8_EXP_LSB  = 3;
   localparam int unsigned FP8_MAN_W    = 3;
   localparam logic [3:0]  FP8_EXP_MAX  = 4'hF;
   localparam logic [7:0]  FP8_QNAN     = 8'h7F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD_B,
      ST_WAIT,
      ST_DONE
   } seq_state_t;

   function automatic logic fp8_is_nan(input logic [7:0] v);
      return (v[FP8_EXP_MSB:FP8_EXP_LSB] == FP8_EXP_MAX) && (v[FP8_MAN_W-1:0] != '0);
   endfunction

   function automatic logic fp8_is_inf(input logic [7:0] v);
      return (v[FP8_EXP_MSB:FP8_EXP_LSB] == FP8_EXP_MAX) && (v[FP8_MAN_W-1:0] == '0);
   endfunction

endpackage

// File: rtl/fp8_operand_sanitize.sv
// Classifies an operand byte and replaces any NaN payload with the canonical
// quiet NaN so the adder only ever sees one NaN encoding.
module fp8_operand_sanitize
   import fp8_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] clean,
   output logic       is_nan,
   output logic       is_inf
);

   assign is_nan = fp8_is_nan(din);
   assign is_inf = fp8_is_inf(din);
   assign clean  = is_nan ? FP8_QNAN : din;

endmodule

// File: rtl/fp8_add_sequencer.sv
// Operand sequencer and result collector for the registered FP8 adder, with an
// optional accumulate mode that feeds each consumed sum back as operand A.
module fp8_add_sequencer
   import fp8_pkg::*;
#(
   parameter int unsigned ADD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       acc_mode,
   input  logic       acc_done,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   output logic       add_ena,
   output logic       add_rst_n,
   input  logic [7:0] add_res,
   output logic [7:0] res,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       nan_seen,
   output logic       inf_seen
);

   localparam int unsigned CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

   seq_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             acc, acc_nxt;
   logic [7:0]       add_a_nxt, add_b_nxt, res_nxt;
   logic             res_valid_nxt, nan_nxt, inf_nxt;

   logic [7:0]       din_clean;
   logic             din_nan, din_inf;
   logic             din_hs;

   fp8_operand_sanitize u_sanitize (
      .din    (din),
      .clean  (din_clean),
      .is_nan (din_nan),
      .is_inf (din_inf)
   );

   assign add_ena   = ~rst;
   assign add_rst_n = ~rst;
   assign din_ready = (state == ST_IDLE) || (state == ST_LOAD_B);
   assign din_hs    = din_valid && din_ready;

   // NOTE: every signal written here gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      acc_nxt       = acc;
      add_a_nxt     = add_a;
      add_b_nxt     = add_b;
      res_nxt       = res;
      res_valid_nxt = res_valid;
      nan_nxt       = nan_seen | (din_hs & din_nan);
      inf_nxt       = inf_seen | (din_hs & din_inf);

      unique case (state)
         ST_IDLE: begin
            if (din_hs) begin
               add_a_nxt = din_clean;
               acc_nxt   = acc_mode;
               state_nxt = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            if (din_hs) begin
               add_b_nxt = din_clean;
               cnt_nxt   = CNT_W'(ADD_LAT);
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               res_nxt       = add_res;
               res_valid_nxt = 1'b1;
               state_nxt     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               if (!acc || acc_done) begin
                  state_nxt = ST_IDLE;
               end else begin
                  // Adder output is already canonical, so it bypasses the sanitiser.
                  add_a_nxt = res;
                  state_nxt = ST_LOAD_B;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         acc       <= 1'b0;
         add_a     <= 8'h00;
         add_b     <= 8'h00;
         res       <= 8'h00;
         res_valid <= 1'b0;
         nan_seen  <= 1'b0;
         inf_seen  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         acc       <= acc_nxt;
         add_a     <= add_a_nxt;
         add_b     <= add_b_nxt;
         res       <= res_nxt;
         res_valid <= res_valid_nxt;
         nan_seen  <= nan_nxt;
         inf_seen  <= inf_nxt;
      end
   end

endmodule
